// File: rtl/park_input_conditioner.sv
// Purpose: conditions parking-lot board inputs (buttons, sensors, token switches) for parking_fsm.
// Latency: raw change -> debounced level/event in 2 + DEBOUNCE_CYCLES cycles; token 2 cycles.
// Backpressure: none; button events are sticky until consumed by fsm_tick. Optional macro: PARK_TOKEN_LATCH_EN.
module park_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int CNT_W             = 20,
    parameter int SENSOR_ACTIVE_LOW = 1
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       entry_btn_raw,
    input  logic       exit_btn_raw,
    input  logic       entry_sensor_raw,
    input  logic       exit_sensor_raw,
    input  logic [4:0] token_input,
    input  logic       fsm_tick,
    output logic       entry_btn_evt,
    output logic       exit_btn_evt,
    output logic       entry_present,
    output logic       exit_present,
    output logic [4:0] token_out
);

    // Channel order: 0 entry button, 1 exit button, 2 entry sensor, 3 exit sensor.
    localparam logic             SENS_IDLE = (SENSOR_ACTIVE_LOW != 0);
    localparam logic [3:0]       IDLE_LVL  = {SENS_IDLE, SENS_IDLE, 1'b0, 1'b0};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       raw_bus;
    logic [3:0]       sync_q1;
    logic [3:0]       sync_q2;
    logic [3:0]       stable;
    logic [3:0]       accept;
    logic [CNT_W-1:0] cnt [4];
    logic [4:0]       tok_q1;
    logic [4:0]       tok_q2;

    assign raw_bus = {exit_sensor_raw, entry_sensor_raw, exit_btn_raw, entry_btn_raw};

    // Two-flop synchronizers; reset loads the idle level so release creates no false edge.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            sync_q1 <= IDLE_LVL;
            sync_q2 <= IDLE_LVL;
            tok_q1  <= '0;
            tok_q2  <= '0;
        end else begin
            sync_q1 <= raw_bus;
            sync_q2 <= sync_q1;
            tok_q1  <= token_input;
            tok_q2  <= tok_q1;
        end
    end

    // A channel accepts its new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (sync_q2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Debounce counters: any sample matching the stable level restarts the count.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            stable <= IDLE_LVL;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync_q2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sticky press events: a new debounced rising edge beats a simultaneous tick clear.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            entry_btn_evt <= 1'b0;
            exit_btn_evt  <= 1'b0;
        end else begin
            entry_btn_evt <= (accept[0] & sync_q2[0]) | (entry_btn_evt & ~fsm_tick);
            exit_btn_evt  <= (accept[1] & sync_q2[1]) | (exit_btn_evt & ~fsm_tick);
        end
    end

    // Sensor outputs come straight from the stable registers, normalised to active-high.
    assign entry_present = stable[2] ^ SENS_IDLE;
    assign exit_present  = stable[3] ^ SENS_IDLE;

`ifdef PARK_TOKEN_LATCH_EN
    logic [4:0] tok_latch;

    // Token is captured on the same edge that raises entry_btn_evt and held until the next press.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            tok_latch <= '0;
        end else if (accept[0] & sync_q2[0]) begin
            tok_latch <= tok_q2;
        end
    end

    assign token_out = tok_latch;
`else
    assign token_out = tok_q2;
`endif

endmodule
